// File: rtl/ps2_frame_rx_if.sv
// Bundle of PS/2 line inputs, the byte handshake and the status outputs of ps2_frame_rx.
// master = line/consumer side, slave = receiver.
interface ps2_frame_rx_if;
    logic       mouse_clock;
    logic       mouse_data;
    logic       rx_en;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        output mouse_clock, mouse_data, rx_en, rx_ack,
        input  rx_data, rx_valid, parity_err, frame_err, overrun, busy
    );

    modport slave (
        input  mouse_clock, mouse_data, rx_en, rx_ack,
        output rx_data, rx_valid, parity_err, frame_err, overrun, busy
    );
endinterface

// File: rtl/ps2_frame_rx.sv
// Device-to-host PS/2 frame receiver: sync + glitch filter, frame FSM, one-entry byte holding register.
//  state | meaning
//  IDLE  | waiting for a start bit (data=0 on a strobe while rx_en=1)
//  SHIFT | collecting d0..d7, parity, stop; timeout armed
//  CHECK | one cycle: judge stop/parity, deliver or drop the byte
module ps2_frame_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic           clk,
    input  logic           rst_n,
    ps2_frame_rx_if.slave  bus
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    state_t         state_q, state_d;
    logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic           filt_clk_q, filt_clk_d;
    logic [FW-1:0]  filt_cnt_q, filt_cnt_d;
    logic           strobe;
    logic [3:0]     bitcnt_q, bitcnt_d;
    logic [9:0]     sr_q, sr_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           rx_valid_q, rx_valid_d;
    logic           parity_err_q, parity_err_d;
    logic           frame_err_q, frame_err_d;
    logic           overrun_q, overrun_d;

    // Filtered clock follows the synced line only after FILTER_LEN equal samples.
    always_comb begin
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        strobe     = 1'b0;
        if (clk_s2_q != filt_clk_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_clk_d = clk_s2_q;
                strobe     = filt_clk_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        sr_d         = sr_q;
        tmo_d        = tmo_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        overrun_d    = overrun_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        if (bus.rx_ack) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
        if (strobe) tmo_d = '0;

        case (state_q)
            IDLE: begin
                if (strobe && bus.rx_en && !dat_s2_q) begin
                    state_d  = SHIFT;
                    bitcnt_d = 4'd1;
                end
            end
            SHIFT: begin
                if (!bus.rx_en) begin
                    state_d = IDLE;
                end else if (strobe) begin
                    sr_d     = {dat_s2_q, sr_q[9:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd10) state_d = CHECK;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (!sr_q[9]) begin
                    frame_err_d = 1'b1;
                end else if (!(^sr_q[8:0])) begin
                    parity_err_d = 1'b1;
                end else if (!rx_valid_q || bus.rx_ack) begin
                    // a same-cycle ack frees the register, so the new byte wins
                    rx_data_d  = sr_q[7:0];
                    rx_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            dat_s1_q     <= 1'b1;
            dat_s2_q     <= 1'b1;
            filt_clk_q   <= 1'b1;
            filt_cnt_q   <= '0;
            state_q      <= IDLE;
            bitcnt_q     <= '0;
            sr_q         <= '0;
            tmo_q        <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            clk_s1_q     <= bus.mouse_clock;
            clk_s2_q     <= clk_s1_q;
            dat_s1_q     <= bus.mouse_data;
            dat_s2_q     <= dat_s1_q;
            filt_clk_q   <= filt_clk_d;
            filt_cnt_q   <= filt_cnt_d;
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            sr_q         <= sr_d;
            tmo_q        <= tmo_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_ps2_frame_rx.sv
// Random and directed PS/2 frames against a frame-level reference; a monitor pops expected
// bytes/error pulses from a scoreboard queue and acks delivered bytes.
module tb_ps2_frame_rx;
    localparam int FLEN = 4;
    localparam int TMO  = 200;
    localparam int HALF = 20;

    localparam int K_BYTE = 0;
    localparam int K_PERR = 1;
    localparam int K_FERR = 2;
    localparam int K_NONE = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   auto_ack = 1'b1;
    exp_t q[$];

    ps2_frame_rx_if bus ();

    ps2_frame_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level reference: what a complete frame received with rx_en=1 must produce.
    task automatic expect_frame(input logic [7:0] d, input logic par, input logic stop);
        exp_t e;
        e.data = d;
        if (!stop)                  e.kind = K_FERR;
        else if ((^d ^ par) != 1'b1) e.kind = K_PERR;
        else                        e.kind = K_BYTE;
        q.push_back(e);
    endtask

    task automatic ps2_bit(input logic b, input bit glitch);
        bus.mouse_data = b;
        if (glitch) begin
            repeat (5) @(negedge clk);
            bus.mouse_clock = 1'b0;
            repeat (2) @(negedge clk);
            bus.mouse_clock = 1'b1;
            repeat (HALF - 7) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        bus.mouse_clock = 1'b0;
        repeat (HALF) @(negedge clk);
        bus.mouse_clock = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int nbits, input bit glitch);
        logic [10:0] f;
        f = {stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i], glitch);
        bus.mouse_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    // Monitor: scoreboard pops on every delivered byte and every error pulse.
    initial begin
        bit   ack_phase;
        bit   prev_pulse;
        int   kind;
        exp_t e;
        ack_phase  = 1'b0;
        prev_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ack_phase  = 1'b0;
                prev_pulse = 1'b0;
                continue;
            end
            if (ack_phase) begin
                bus.rx_ack = 1'b0;
                ack_phase  = 1'b0;
                check("ack_clears_valid", bus.rx_valid, 0);
            end else if (auto_ack && bus.rx_valid) begin
                if (q.size() > 0) e = q.pop_front();
                else begin e.kind = K_NONE; e.data = 8'h00; end
                check("byte_kind", K_BYTE, e.kind);
                check("byte_data", bus.rx_data, e.data);
                bus.rx_ack = 1'b1;
                ack_phase  = 1'b1;
            end
            if (bus.parity_err || bus.frame_err) begin
                kind = bus.parity_err ? K_PERR : K_FERR;
                if (q.size() > 0) e = q.pop_front();
                else begin e.kind = K_NONE; e.data = 8'h00; end
                check("err_kind", kind, e.kind);
                check("err_exclusive", bus.parity_err & bus.frame_err, 0);
                check("err_width", prev_pulse, 0);
            end
            prev_pulse = bus.parity_err | bus.frame_err;
        end
    end

    initial begin
        logic [7:0] d;
        logic       par, stop;
        int         r;
        bit         gl;

        rst_n           = 1'b0;
        bus.mouse_clock = 1'b1;
        bus.mouse_data  = 1'b1;
        bus.rx_en       = 1'b1;
        bus.rx_ack      = 1'b0;
        @(negedge clk);
        check("rst_valid", bus.rx_valid, 0);
        check("rst_data", bus.rx_data, 8'h00);
        check("rst_busy", bus.busy, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_errs", {bus.parity_err, bus.frame_err}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // good 0xFA, then 0x08 with bad parity
        expect_frame(8'hFA, 1'b1, 1'b1);
        send_frame(8'hFA, 1'b1, 1'b1, 11, 1'b0);
        expect_frame(8'h08, 1'b1, 1'b1);
        send_frame(8'h08, 1'b1, 1'b1, 11, 1'b0);
        check("perr_valid", bus.rx_valid, 0);
        check("perr_data_kept", bus.rx_data, 8'hFA);

        // overrun
        auto_ack = 1'b0;
        send_frame(8'h08, ~^8'h08, 1'b1, 11, 1'b0);
        check("ovr_first_valid", bus.rx_valid, 1);
        check("ovr_first_data", bus.rx_data, 8'h08);
        send_frame(8'h1C, ~^8'h1C, 1'b1, 11, 1'b0);
        check("ovr_flag", bus.overrun, 1);
        check("ovr_data_kept", bus.rx_data, 8'h08);
        check("ovr_valid", bus.rx_valid, 1);
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
        check("ovr_cleared", bus.overrun, 0);
        check("ovr_valid_cleared", bus.rx_valid, 0);
        auto_ack = 1'b1;

        // timeout after 5 bits, then a clean 0x55
        expect_frame(8'h00, 1'b0, 1'b0);
        send_frame(8'h15, 1'b0, 1'b1, 5, 1'b0);
        repeat (TMO + 10) @(negedge clk);
        check("tmo_busy", bus.busy, 0);
        expect_frame(8'h55, ~^8'h55, 1'b1);
        send_frame(8'h55, ~^8'h55, 1'b1, 11, 1'b0);

        // glitches on every high phase
        expect_frame(8'hA5, ~^8'hA5, 1'b1);
        send_frame(8'hA5, ~^8'hA5, 1'b1, 11, 1'b1);
        check("glitch_data", bus.rx_data, 8'hA5);

        // reset mid-frame at bit 6
        send_frame(8'hC3, 1'b1, 1'b1, 7, 1'b0);
        check("pre_rst_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", bus.rx_data, 8'h00);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_valid", bus.rx_valid, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expect_frame(8'h3C, ~^8'h3C, 1'b1);
        send_frame(8'h3C, ~^8'h3C, 1'b1, 11, 1'b0);
        check("post_rst_data", bus.rx_data, 8'h3C);

        // rx_en dropped mid-frame: silent abort; a frame with rx_en=0 is ignored
        send_frame(8'h99, 1'b1, 1'b1, 5, 1'b0);
        check("en_pre_busy", bus.busy, 1);
        bus.rx_en = 1'b0;
        repeat (3) @(negedge clk);
        check("en_abort_busy", bus.busy, 0);
        repeat (TMO + 10) @(negedge clk);
        send_frame(8'h77, ~^8'h77, 1'b1, 11, 1'b0);
        check("en_off_valid", bus.rx_valid, 0);
        check("en_off_busy", bus.busy, 0);
        bus.rx_en = 1'b1;

        // randomized frames
        for (int n = 0; n < 25; n++) begin
            d    = 8'($urandom);
            r    = $urandom_range(0, 9);
            gl   = 1'($urandom_range(0, 1));
            par  = ~^d;
            stop = 1'b1;
            if (r == 8) par  = ^d;
            if (r == 9) stop = 1'b0;
            expect_frame(d, par, stop);
            send_frame(d, par, stop, 11, gl);
        end

        repeat (50) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
